bcd_display_scanner: RTL
========================

// Module: bcd_display_scanner
// PURPOSE
//  Multiplexed N-digit 7-segment driver for the reaction-timer score/time readout.
//  Takes a packed BCD value and scans one digit per refresh slot.
//  Decodes each digit with optional hex and leading-zero blanking.
//  Holds a frozen snapshot of the value while freeze is high.
// PARAMETERS
//  N_DIGITS     4      number of digits (2..8); digit 0 is least significant
//  REFRESH_DIV  50000  clk cycles per digit slot (>=2)
//  ACTIVE_LOW   1      1: seg/dp/an low = lit/enabled; 0: high = lit/enabled
//  HEX_EN       0      1: codes 10-15 shown as A b C d E F; 0: shown as '-'
//  BLANK_LZ     1      1: blank leading zero digits (digit 0 never blanked)
// PORTS
//  clk         in   1            system clock, rising edge
//  rst         in   1            async active-high reset
//  value_in    in   4*N_DIGITS   packed BCD; digit d = value_in[4d+3:4d]
//  dp_in       in   N_DIGITS     decimal point request per digit
//  freeze      in   1            level; high = snapshot mode, low = live/clear
//  capture     in   1            1-cycle strobe; loads snapshot when freeze high
//  held        out  1            1 = display shows the snapshot
//  snap_out    out  4*N_DIGITS   snapshot register contents
//  seg         out  7            segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//  dp          out  1            decimal point of the active digit
//  an          out  N_DIGITS     one-hot digit enable, polarity per ACTIVE_LOW
// BEHAVIOUR
//  Reset (async): snap_out=0, held=0, prescaler=0, idx=0.
//   seg/dp = all off; an = all disabled.
//  Snapshot:
//   - freeze low: snap_out<=0, held<=0 each cycle; capture ignored.
//   - freeze high, held=0, capture=1: snap_out<=value_in, held<=1.
//   - freeze high, held=1: snap_out holds; further captures ignored.
//     Only freeze low re-arms the snapshot.
//   - freeze falling and capture in the same cycle: clear wins.
//  Display source: src = held ? snap_out : value_in, sampled at the slot boundary.
//  Scan:
//   - prescaler counts 0..REFRESH_DIV-1 and wraps.
//   - On wrap, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
//   - seg/dp/an are registered. They update in the cycle after idx changes.
//     Latency: 1 clk from idx to pins.
//   - The first digit is driven 1 clk after reset release, with idx=0.
//   - Exactly one an bit is enabled outside reset.
//  Decode (ACTIVE_LOW=1 patterns; invert when ACTIVE_LOW=0):
//   0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//   5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//   A=0001000  b=0000011  C=1000110  d=0100001  E=0000110  F=0001110
//   '-'=0111111  blank=1111111
//  Blanking:
//   - Digit d>0 is blanked when BLANK_LZ=1 and src digits N-1..d are all 0.
//   - A blanked digit also suppresses dp, even if dp_in[d]=1.
//   - an is still enabled during a blanked slot to keep scan timing uniform.
//  A value_in change mid-slot does not alter pins until the next slot boundary.
//  Reset asserted mid-scan: pins go off immediately (async). Scan restarts at idx=0.
// TESTING (N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1, BLANK_LZ=1, HEX_EN=0)
//  1 Reset then release, value_in=16'h1234:
//     an cycles 1110,1101,1011,0111 every 4 clk.
//     seg per slot = 0011001,0110000,0100100,1111001.
//  2 value_in=16'h0007:
//     digit0 seg=1111000.
//     digits 1-3 seg=1111111 with dp blanked.
//     value 0 -> digit0 shows 1000000.
//  3 freeze=1, capture pulse with value_in=16'h0250, then value_in=16'h9999:
//     held=1, snap_out=16'h0250, display unchanged.
//     A second capture is ignored.
//  4 freeze 1->0 in the same cycle as capture:
//     held=0, snap_out=0 next cycle, display follows value_in.
//  5 value_in=16'h00AF, HEX_EN=0 then 1:
//     digit0 shows '-' then F=0001110.
//     digit1 shows '-' then A=0001000.
//  6 Assert rst mid-slot on idx=2:
//     seg=1111111, an=1111 immediately.
//     After release, idx=0 drives first.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: multiplexed BCD 7-segment scanner with leading-zero blanking and a frozen snapshot
module bcd_display_scanner #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1,
    parameter int HEX_EN      = 0,
    parameter int BLANK_LZ    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    freeze,
    input  logic                    capture,
    output logic                    held,
    output logic [4*N_DIGITS-1:0]   snap_out,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an
);
    localparam int IW = $clog2(N_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [6:0] seg_off = (ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [6:0] seg_dash = 7'b0111111;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    load;
    logic                    wrap;
    logic [4*N_DIGITS-1:0]   src;
    logic [N_DIGITS-1:0]     blank;
    logic                    nz;
    logic [3:0]              dig;
    logic [6:0]              pat;
    logic                    lit_dp;
    logic [N_DIGITS-1:0]     en;

    // active-low segment patterns {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'ha: decode = 7'b0001000;
            4'hb: decode = 7'b0000011;
            4'hc: decode = 7'b1000110;
            4'hd: decode = 7'b0100001;
            4'he: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign wrap = presc == PW'(REFRESH_DIV - 1);
    assign src  = held ? snap_out : value_in;

    // snapshot: freeze low clears and re-arms, first capture while frozen latches value_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held     <= 1'b0;
            snap_out <= '0;
        end else if (!freeze) begin
            held     <= 1'b0;
            snap_out <= '0;
        end else if (!held && capture) begin
            held     <= 1'b1;
            snap_out <= value_in;
        end
    end

    // slot timer and digit index; load marks the first cycle of each new slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            load  <= 1'b1;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            load  <= wrap;
            if (wrap)
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // leading-zero scan from the top digit down; digit 0 is never blanked
    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            nz       = nz | (src[4*d +: 4] != 4'h0);
            blank[d] = (BLANK_LZ != 0) && (d != 0) && !nz;
        end
    end

    // decode the active digit in lit-low form before polarity is applied
    always_comb begin
        dig    = src[idx*4 +: 4];
        pat    = blank[idx] ? 7'h7f : (dig > 4'd9 && HEX_EN == 0) ? seg_dash : decode(dig);
        lit_dp = dp_in[idx] & ~blank[idx];
        en     = N_DIGITS'(1) << idx;
    end

    // pins change only at slot start so mid-slot input changes never glitch the display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= seg_off;
            dp  <= (ACTIVE_LOW != 0);
            an  <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else if (load) begin
            seg <= (ACTIVE_LOW != 0) ? pat : ~pat;
            dp  <= (ACTIVE_LOW != 0) ? ~lit_dp : lit_dp;
            an  <= (ACTIVE_LOW != 0) ? ~en : en;
        end
    end
endmodule
